// File: rtl/i2s_audio_tx_pkg.sv
// Shared definitions for the I2S/TDM transmitter.
//   FMT_I2S / FMT_LJ : serial data alignment (Philips 1-bit delay / left-justified)
//   clog2            : ceiling log2 with a floor of 1, used for counter and pointer widths
package i2s_audio_tx_pkg;

  localparam int FMT_I2S = 0;
  localparam int FMT_LJ  = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/i2s_audio_tx_sync_fifo.sv
// Single-clock frame FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, wr_data : write request and data (ignored while full)
//   pop, rd_data  : read request (ignored while empty); rd_data shows the head entry
//   full, empty, level : occupancy flags and entry count
module i2s_audio_tx_sync_fifo
  import i2s_audio_tx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S / TDM audio serialiser with a frame FIFO.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   en            : serialiser enable; low clears clocks, counters and shift register
//   s_data        : one frame, channel 0 in the LSBs, two's complement
//   s_valid/ready : frame input handshake
//   fifo_level    : frames stored
//   underrun      : sticky, a frame start found the FIFO empty (cleared by reset or en=0)
//   i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdin : pins to the DAC
//
// Handshake: a frame is transferred on every clk edge where s_valid && s_ready;
// s_ready is high whenever the FIFO is not full (and low while in reset), and it
// does not depend on s_valid. s_data must be stable while s_valid is high.
module i2s_audio_tx
  import i2s_audio_tx_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int MCLK_DIV   = 2,
  parameter int SCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FMT_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                         underrun,
  output logic                         i2s_mclk,
  output logic                         i2s_sclk,
  output logic                         i2s_lrclk,
  output logic                         i2s_sdin
);

  localparam int FRAME    = CHANNELS * SLOT_W;
  localparam int DW       = CHANNELS * SAMPLE_W;
  localparam int SCLK_LEN = MCLK_DIV * SCLK_DIV;   // clk cycles per SCLK period
  localparam int MW       = clog2(MCLK_DIV);
  localparam int CW       = clog2(SCLK_LEN);
  localparam int PW       = clog2(FRAME);

  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV - 1);
  localparam logic [MW-1:0] MCLK_HALF = MW'(MCLK_DIV / 2);
  localparam logic [CW-1:0] SCLK_LAST = CW'(SCLK_LEN - 1);
  localparam logic [CW-1:0] SCLK_HALF = CW'(SCLK_LEN / 2);
  localparam logic [PW-1:0] POS_LAST  = PW'(FRAME - 1);
  localparam logic [PW-1:0] POS_SLOT1 = PW'(SLOT_W);

  logic             alive;
  logic [MW-1:0]    mclk_cnt;
  logic [CW-1:0]    sclk_cnt;
  logic [PW-1:0]    pos;        // SCLK period index within the current frame
  logic [PW-1:0]    next_pos;
  logic             started;    // a frame has begun since en went high
  logic [FRAME-1:0] sreg;
  logic [FRAME-1:0] load_vec;
  logic [DW-1:0]    frame_src;
  logic             lj_bit;     // data bit in left-justified timing
  logic             dly_bit;    // same bit one SCLK later (Philips timing)
  logic             mclk_q, sclk_q, lrclk_q, lr_next;
  logic             fall, frame_start;
  logic [DW-1:0]    fifo_rd;
  logic             fifo_full, fifo_empty;

  i2s_audio_tx_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (s_valid && s_ready),
    .wr_data (s_data),
    .pop     (frame_start),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign s_ready = alive && !fifo_full;

  // A falling SCLK edge is produced on the clk edge where the SCLK phase counter
  // reaches the half period; every frame boundary sits on one of these.
  assign fall        = en && (sclk_cnt == SCLK_HALF);
  assign frame_start = fall && (!started || (pos == POS_LAST));
  assign next_pos    = frame_start ? '0 : pos + 1'b1;

  // Each sample goes MSB-first at the top of its slot, zero padded below.
  always_comb begin
    frame_src = fifo_empty ? '0 : fifo_rd;
    load_vec  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      load_vec[FRAME-1-c*SLOT_W -: SAMPLE_W] = frame_src[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    lr_next = 1'b0;
    if (CHANNELS == 2)           lr_next = (next_pos >= POS_SLOT1);
    else if (FMT_MODE == FMT_LJ) lr_next = (next_pos == '0);
    else                         lr_next = (next_pos == POS_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_cnt <= '0;
      sclk_cnt <= '0;
      pos      <= '0;
      started  <= 1'b0;
      sreg     <= '0;
      lj_bit   <= 1'b0;
      dly_bit  <= 1'b0;
      mclk_q   <= 1'b0;
      sclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
    end else if (!en) begin
      mclk_cnt <= '0;
      sclk_cnt <= '0;
      pos      <= '0;
      started  <= 1'b0;
      sreg     <= '0;
      lj_bit   <= 1'b0;
      dly_bit  <= 1'b0;
      mclk_q   <= 1'b0;
      sclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
    end else begin
      mclk_cnt <= (mclk_cnt == MCLK_LAST) ? '0 : mclk_cnt + 1'b1;
      sclk_cnt <= (sclk_cnt == SCLK_LAST) ? '0 : sclk_cnt + 1'b1;
      // Both clocks start their high phase on the first enabled edge.
      mclk_q   <= (mclk_cnt < MCLK_HALF);
      sclk_q   <= (sclk_cnt < SCLK_HALF);
      if (fall) begin
        started <= 1'b1;
        pos     <= next_pos;
        lrclk_q <= lr_next;
        dly_bit <= lj_bit;
        if (frame_start) begin
          lj_bit <= load_vec[FRAME-1];
          sreg   <= {load_vec[FRAME-2:0], 1'b0};
        end else begin
          lj_bit <= sreg[FRAME-1];
          sreg   <= {sreg[FRAME-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           underrun <= 1'b0;
    else if (!en)                         underrun <= 1'b0;
    else if (frame_start && fifo_empty)   underrun <= 1'b1;
  end

  assign i2s_mclk  = mclk_q;
  assign i2s_sclk  = sclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdin  = (FMT_MODE == FMT_I2S) ? dly_bit : lj_bit;

endmodule
